// File: rtl/rx_pkg.sv
// rtl/rx_pkg.sv - shared types and defaults for the Rx framing stage
package rx_pkg;

    localparam int BYTE_W = 8;
    localparam logic [BYTE_W-1:0] SYNC_WORD_DEF = 8'hA5;
    localparam int MAX_LEN_DEF = 16;

    typedef enum logic [1:0] {
        HUNT,
        LEN,
        DATA,
        CHK
    } rx_state_t;

endpackage

// File: rtl/rx_bit_sampler.sv
// rtl/rx_bit_sampler.sv - comparator bit synchronizer and bit-clock edge strobe
module rx_bit_sampler (
    input  logic aclk,
    input  logic reset,
    input  logic pclk,
    input  logic rx_bit,
    output logic tick,
    output logic sample_bit
);

    logic sync_1;
    logic sync_2;
    logic pclk_q;

    always_ff @(posedge aclk) begin
        if (reset) begin
            sync_1 <= 1'b0;
            sync_2 <= 1'b0;
            pclk_q <= 1'b0;
        end else begin
            sync_1 <= rx_bit;
            sync_2 <= sync_1;
            pclk_q <= pclk;
        end
    end

    assign tick       = pclk & ~pclk_q;
    assign sample_bit = sync_2;

endmodule

// File: rtl/rx_frame_deframer.sv
// rtl/rx_frame_deframer.sv - sync hunt and length/XOR framed byte deserializer
module rx_frame_deframer
    import rx_pkg::*;
#(
    parameter logic [BYTE_W-1:0] SYNC_WORD = SYNC_WORD_DEF,
    parameter int                MAX_LEN   = MAX_LEN_DEF
) (
    input  logic              aclk,
    input  logic              reset,
    input  logic              pclk,
    input  logic              rx_bit,
    output logic [BYTE_W-1:0] m_data,
    output logic              m_valid,
    output logic              m_last,
    input  logic              m_ready,
    output logic              frame_ok,
    output logic              frame_err,
    output logic              overflow
);

    localparam logic [BYTE_W-1:0] MAX_LEN_B = BYTE_W'(MAX_LEN);

    logic              tick;
    logic              sample_bit;
    rx_state_t         state, state_d;
    logic [BYTE_W-1:0] window, window_d;
    logic [2:0]        bit_cnt, bit_cnt_d;
    logic [BYTE_W-1:0] remaining, remaining_d;
    logic [BYTE_W-1:0] checksum, checksum_d;
    logic [BYTE_W-1:0] m_data_d;
    logic              m_valid_d, m_last_d, frame_ok_d, frame_err_d, overflow_d;
    logic [BYTE_W-1:0] byte_in;
    logic              byte_done;

    rx_bit_sampler u_sampler (
        .aclk       (aclk),
        .reset      (reset),
        .pclk       (pclk),
        .rx_bit     (rx_bit),
        .tick       (tick),
        .sample_bit (sample_bit)
    );

    assign byte_in   = {window[BYTE_W-2:0], sample_bit};
    assign byte_done = (bit_cnt == 3'd7);

    always_ff @(posedge aclk) begin
        if (reset) begin
            state     <= HUNT;
            window    <= '0;
            bit_cnt   <= '0;
            remaining <= '0;
            checksum  <= '0;
            m_data    <= '0;
            m_valid   <= 1'b0;
            m_last    <= 1'b0;
            frame_ok  <= 1'b0;
            frame_err <= 1'b0;
            overflow  <= 1'b0;
        end else begin
            state     <= state_d;
            window    <= window_d;
            bit_cnt   <= bit_cnt_d;
            remaining <= remaining_d;
            checksum  <= checksum_d;
            m_data    <= m_data_d;
            m_valid   <= m_valid_d;
            m_last    <= m_last_d;
            frame_ok  <= frame_ok_d;
            frame_err <= frame_err_d;
            overflow  <= overflow_d;
        end
    end

    always_comb begin
        state_d     = state;
        window_d    = window;
        bit_cnt_d   = bit_cnt;
        remaining_d = remaining;
        checksum_d  = checksum;
        m_data_d    = m_data;
        m_valid_d   = m_valid;
        m_last_d    = m_last;
        frame_ok_d  = 1'b0;
        frame_err_d = 1'b0;
        overflow_d  = overflow;

        // Handshake is independent of the bit clock; a byte landing below may re-set valid.
        if (m_valid && m_ready) begin
            m_valid_d = 1'b0;
        end

        if (tick) begin
            window_d  = byte_in;
            bit_cnt_d = bit_cnt + 3'd1;
            unique case (state)
                HUNT: begin
                    bit_cnt_d = 3'd0;
                    if (byte_in == SYNC_WORD) begin
                        state_d = LEN;
                    end
                end
                LEN: begin
                    if (byte_done) begin
                        if (byte_in == '0 || byte_in > MAX_LEN_B) begin
                            frame_err_d = 1'b1;
                            state_d     = HUNT;
                        end else begin
                            remaining_d = byte_in;
                            checksum_d  = '0;
                            state_d     = DATA;
                        end
                    end
                end
                DATA: begin
                    if (byte_done) begin
                        checksum_d = checksum ^ byte_in;
                        if (remaining != '0) begin
                            remaining_d = remaining - 8'd1;
                        end
                        // A still-unaccepted byte is kept; the newcomer is lost.
                        if (!m_valid || m_ready) begin
                            m_data_d  = byte_in;
                            m_last_d  = (remaining == 8'd1);
                            m_valid_d = 1'b1;
                        end else begin
                            overflow_d = 1'b1;
                        end
                        if (remaining <= 8'd1) begin
                            state_d = CHK;
                        end
                    end
                end
                CHK: begin
                    if (byte_done) begin
                        frame_ok_d  = (byte_in == checksum);
                        frame_err_d = (byte_in != checksum);
                        window_d    = '0;
                        state_d     = HUNT;
                    end
                end
                default: state_d = HUNT;
            endcase
        end
    end

endmodule

// File: tb/tb_rx_frame_deframer.sv
// tb/tb_rx_frame_deframer.sv - directed frame-level bench for rx_frame_deframer
module tb_rx_frame_deframer;

    localparam int MAXL = 16;

    logic       aclk = 1'b0;
    logic       reset = 1'b1;
    logic       pclk = 1'b0;
    logic       rx_bit = 1'b0;
    logic       m_ready = 1'b1;
    logic [7:0] m_data;
    logic       m_valid, m_last, frame_ok, frame_err, overflow;

    int         total = 0;
    int         bad = 0;
    logic [8:0] exp_q[$];
    int         ev_q[$];
    logic [7:0] tx[$];
    logic [7:0] last_seen = 8'h00;
    int         ok_seen = 0;
    int         err_seen = 0;
    logic [8:0] exp_b;
    int         exp_ev;

    rx_frame_deframer #(.SYNC_WORD(8'hA5), .MAX_LEN(MAXL)) dut (
        .aclk      (aclk),
        .reset     (reset),
        .pclk      (pclk),
        .rx_bit    (rx_bit),
        .m_data    (m_data),
        .m_valid   (m_valid),
        .m_last    (m_last),
        .m_ready   (m_ready),
        .frame_ok  (frame_ok),
        .frame_err (frame_err),
        .overflow  (overflow)
    );

    always #5 aclk = ~aclk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    always @(negedge aclk) begin
        if (!reset) begin
            if (m_valid && m_ready) begin
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL stray_byte actual=%0h required=none", m_data);
                end else begin
                    exp_b = exp_q.pop_front();
                    chk("byte_last_data", {23'd0, m_last, m_data}, {23'd0, exp_b});
                    last_seen = m_data;
                end
            end
            if (frame_ok || frame_err) begin
                if (frame_ok) ok_seen++;
                if (frame_err) err_seen++;
                if (ev_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL stray_pulse actual=ok%0d_err%0d required=none", frame_ok, frame_err);
                end else begin
                    exp_ev = ev_q.pop_front();
                    chk("frame_result", {30'd0, frame_err, frame_ok}, exp_ev);
                end
            end
        end
    end

    task automatic cyc();
        @(posedge aclk);
        #1;
    endtask

    task automatic send_bit(input logic b, input int hold);
        rx_bit = b;
        repeat (3) cyc();
        pclk = 1'b1;
        repeat (hold) cyc();
        pclk = 1'b0;
        repeat (2) cyc();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) send_bit(1'b0, 5);
    endtask

    task automatic send_tx(input int hold_idx);
        int k = 0;
        for (int i = 0; i < tx.size(); i++) begin
            for (int j = 7; j >= 0; j--) begin
                send_bit(tx[i][j], (k == hold_idx) ? 30 : 5);
                k++;
            end
        end
    endtask

    // Frame semantics: sync, length, payload, XOR check byte.
    task automatic model_frame(input bit ready);
        int len;
        logic [7:0] x;
        len = int'(tx[1]);
        x = 8'h00;
        if (len == 0 || len > MAXL) begin
            ev_q.push_back(2);
            return;
        end
        for (int i = 0; i < len; i++) begin
            x = x ^ tx[2+i];
            if (ready) exp_q.push_back({(i == len - 1) ? 1'b1 : 1'b0, tx[2+i]});
        end
        ev_q.push_back((x == tx[len+2]) ? 1 : 2);
    endtask

    task automatic run_frame(input bit ready, input int hold_idx);
        model_frame(ready);
        send_tx(hold_idx);
        idle(8);
    endtask

    initial begin
        repeat (3) cyc();
        reset = 1'b0;
        cyc();
        chk("rst_m_data", {24'd0, m_data}, 0);
        chk("rst_m_valid", {31'd0, m_valid}, 0);
        chk("rst_m_last", {31'd0, m_last}, 0);
        chk("rst_frame_ok", {31'd0, frame_ok}, 0);
        chk("rst_frame_err", {31'd0, frame_err}, 0);
        chk("rst_overflow", {31'd0, overflow}, 0);

        idle(40);
        chk("idle_no_pulse", ok_seen + err_seen, 0);

        tx = '{8'hA5, 8'h02, 8'h3C, 8'hC3, 8'hFF};
        run_frame(1'b1, -1);
        chk("t1_exp_empty", exp_q.size(), 0);
        chk("t1_ev_empty", ev_q.size(), 0);
        chk("t1_last_byte", {24'd0, last_seen}, 32'hC3);
        chk("t1_ok_count", ok_seen, 1);

        tx = '{8'hA5, 8'h02, 8'h3C, 8'hC3, 8'h00};
        run_frame(1'b1, -1);
        tx = '{8'hA5, 8'h02, 8'h3C, 8'hC3, 8'hFF};
        run_frame(1'b1, -1);
        chk("t2_err_count", err_seen, 1);
        chk("t2_ok_count", ok_seen, 2);

        tx = '{8'hA5, 8'h00};
        run_frame(1'b1, -1);
        tx = '{8'hA5, 8'h11};
        run_frame(1'b1, -1);
        chk("t3_err_count", err_seen, 3);
        chk("t3_no_bytes", exp_q.size(), 0);

        send_bit(1'b1, 5); send_bit(1'b0, 5); send_bit(1'b1, 5); send_bit(1'b0, 5);
        send_bit(1'b0, 5); send_bit(1'b1, 5); send_bit(1'b0, 5); send_bit(1'b0, 5);
        tx = '{8'hA5, 8'h02, 8'h3C, 8'hC3, 8'hFF};
        run_frame(1'b1, 20);
        chk("t4_ok_count", ok_seen, 3);
        chk("t4_err_count", err_seen, 3);
        chk("t4_ev_empty", ev_q.size(), 0);

        m_ready = 1'b0;
        tx = '{8'hA5, 8'h03, 8'h11, 8'h22, 8'h33, 8'h00};
        run_frame(1'b0, -1);
        chk("t5_valid_held", {31'd0, m_valid}, 1);
        chk("t5_data_held", {24'd0, m_data}, 32'h11);
        chk("t5_last_held", {31'd0, m_last}, 0);
        chk("t5_overflow", {31'd0, overflow}, 1);
        chk("t5_ok_count", ok_seen, 4);
        exp_q.push_back({1'b0, 8'h11});
        m_ready = 1'b1;
        cyc();
        cyc();
        chk("t5_drained", exp_q.size(), 0);
        chk("t5_valid_clear", {31'd0, m_valid}, 0);
        reset = 1'b1;
        cyc();
        reset = 1'b0;
        chk("t5_overflow_rst", {31'd0, overflow}, 0);

        m_ready = 1'b0;
        tx = '{8'hA5, 8'h02, 8'h3C};
        send_tx(-1);
        chk("t6_valid_pre", {31'd0, m_valid}, 1);
        chk("t6_data_pre", {24'd0, m_data}, 32'h3C);
        reset = 1'b1;
        cyc();
        reset = 1'b0;
        chk("t6_valid_rst", {31'd0, m_valid}, 0);
        chk("t6_data_rst", {24'd0, m_data}, 0);
        chk("t6_last_rst", {31'd0, m_last}, 0);
        m_ready = 1'b1;
        idle(8);
        tx = '{8'hA5, 8'h02, 8'h3C, 8'hC3, 8'hFF};
        run_frame(1'b1, -1);
        chk("t6_ok_count", ok_seen, 5);
        chk("t6_last_byte", {24'd0, last_seen}, 32'hC3);
        chk("end_exp_empty", exp_q.size(), 0);
        chk("end_ev_empty", ev_q.size(), 0);
        chk("end_overflow", {31'd0, overflow}, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
